// File: rtl/usb_tx_linecode.sv
// USB low/full-speed transmit line coder: bit stuffing, NRZI, SE0/J end-of-packet.
// Define USB_TX_SYNC_GEN_EN to emit the 8'h80 SYNC pattern ahead of the first word.
module usb_tx_linecode #(
  parameter int DATA_W      = 8,
  parameter int STUFF_LIMIT = 6
) (
  input  logic              gclk,
  input  logic              reset_l,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  output logic              tx_ready,
  output logic              dp_out,
  output logic              dm_out,
  output logic              tx_oe,
  output logic              underrun
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
  localparam logic [2:0]    LIMIT    = 3'(STUFF_LIMIT);

`ifdef USB_TX_SYNC_GEN_EN
  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;
`else
  typedef enum logic [2:0] {IDLE, DATA, STUFF, EOP_SE0, EOP_J} state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] shift_q;
  logic [CW-1:0]     bit_cnt;
  logic [2:0]        ones_cnt;
  logic              last_q;
  logic              stuff_final_q;
  logic              word_end;
  logic              next_bit;

  // The word on the line is finished: its last bit is out and needs no stuff bit,
  // or the stuff bit that followed its last bit is out.
  assign word_end = ((state == DATA) && (bit_cnt == LAST_BIT) && (ones_cnt != LIMIT)) ||
                    ((state == STUFF) && stuff_final_q);
  assign tx_ready = (state == IDLE) || (word_end && !last_q);

  always_comb begin
    next_bit = shift_q[0];
    if ((state == IDLE) || word_end) next_bit = tx_data[0];
`ifdef USB_TX_SYNC_GEN_EN
    if ((state == SYNC) && (bit_cnt != CW'(7))) next_bit = (bit_cnt == CW'(6));
`endif
  end

  // dp_out/dm_out double as the NRZI level while data is on the line: a 0 toggles.
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      state         <= IDLE;
      dp_out        <= 1'b1;
      dm_out        <= 1'b0;
      tx_oe         <= 1'b0;
      underrun      <= 1'b0;
      ones_cnt      <= '0;
      bit_cnt       <= '0;
      shift_q       <= '0;
      last_q        <= 1'b0;
      stuff_final_q <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          dp_out   <= 1'b1;
          dm_out   <= 1'b0;
          tx_oe    <= 1'b0;
          ones_cnt <= '0;
          bit_cnt  <= '0;
          if (tx_valid) begin
            tx_oe  <= 1'b1;
            last_q <= tx_last;
`ifdef USB_TX_SYNC_GEN_EN
            state   <= SYNC;
            shift_q <= tx_data;
            dp_out  <= 1'b0;
            dm_out  <= 1'b1;
`else
            state    <= DATA;
            shift_q  <= tx_data >> 1;
            dp_out   <= next_bit;
            dm_out   <= ~next_bit;
            ones_cnt <= {2'b00, next_bit};
`endif
          end
        end
`ifdef USB_TX_SYNC_GEN_EN
        SYNC: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(7)) begin
            state   <= DATA;
            bit_cnt <= '0;
            shift_q <= shift_q >> 1;
          end
          if (next_bit) begin
            ones_cnt <= ones_cnt + 3'd1;
          end else begin
            ones_cnt <= '0;
            dp_out   <= ~dp_out;
            dm_out   <= ~dm_out;
          end
        end
`endif
        DATA, STUFF: begin
          if (word_end) begin
            if (last_q || !tx_valid) begin
              state    <= EOP_SE0;
              dp_out   <= 1'b0;
              dm_out   <= 1'b0;
              bit_cnt  <= '0;
              ones_cnt <= '0;
              underrun <= !last_q;
            end else begin
              state   <= DATA;
              shift_q <= tx_data >> 1;
              last_q  <= tx_last;
              bit_cnt <= '0;
              if (next_bit) begin
                ones_cnt <= ones_cnt + 3'd1;
              end else begin
                ones_cnt <= '0;
                dp_out   <= ~dp_out;
                dm_out   <= ~dm_out;
              end
            end
          end else if ((state == DATA) && (ones_cnt == LIMIT)) begin
            state         <= STUFF;
            stuff_final_q <= (bit_cnt == LAST_BIT);
            ones_cnt      <= '0;
            dp_out        <= ~dp_out;
            dm_out        <= ~dm_out;
          end else begin
            state   <= DATA;
            bit_cnt <= bit_cnt + 1'b1;
            shift_q <= shift_q >> 1;
            if (next_bit) begin
              ones_cnt <= ones_cnt + 3'd1;
            end else begin
              ones_cnt <= '0;
              dp_out   <= ~dp_out;
              dm_out   <= ~dm_out;
            end
          end
        end
        EOP_SE0: begin
          if (bit_cnt == '0) begin
            bit_cnt <= CW'(1);
          end else begin
            state   <= EOP_J;
            dp_out  <= 1'b1;
            dm_out  <= 1'b0;
            bit_cnt <= '0;
          end
        end
        EOP_J: begin
          state <= IDLE;
          tx_oe <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_linecode.sv
// Table-driven bench for usb_tx_linecode (DATA_W=8, STUFF_LIMIT=6).
// Line symbols: J/K = driven level (lowercase: tx_ready also high), S = SE0, U = SE0 with underrun, I = idle J.
module tb_usb_tx_linecode;

  logic       gclk = 1'b0;
  logic       reset_l;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       dp_out;
  logic       dm_out;
  logic       tx_oe;
  logic       underrun;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0]   w0;
    logic         last0;
    logic [7:0]   w1;
    logic         send_w1;
    logic [255:0] exp_line;
  } vec_t;

  vec_t vecs[$];

  usb_tx_linecode #(.DATA_W(8), .STUFF_LIMIT(6)) dut (
    .gclk     (gclk),
    .reset_l  (reset_l),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .dp_out   (dp_out),
    .dm_out   (dm_out),
    .tx_oe    (tx_oe),
    .underrun (underrun)
  );

  always #5 gclk = ~gclk;

  function automatic logic [255:0] mk(input string s);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r = {r[247:0], 8'(s[i])};
    return r;
  endfunction

  // Expected {dp, dm, tx_oe, underrun, tx_ready} for one line symbol.
  function automatic logic [4:0] sym_exp(input logic [7:0] c);
    case (c)
      "J":     return 5'b10100;
      "j":     return 5'b10101;
      "K":     return 5'b01100;
      "k":     return 5'b01101;
      "S":     return 5'b00100;
      "U":     return 5'b00110;
      default: return 5'b10001;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] c);
    logic [4:0] got;
    logic [4:0] want;
    got  = {dp_out, dm_out, tx_oe, underrun, tx_ready};
    want = sym_exp(c);
    n_checks++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s: dp/dm/oe/underrun/ready got %b required %b (%s)",
                  name, got, want, string'(c));
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int   len;
    logic hs;
    logic pending_w1;
    len = 0;
    for (int b = 0; b < 32; b++) if (v.exp_line[8*b +: 8] != 8'h00) len++;
    tx_valid   = 1'b1;
    tx_data    = v.w0;
    tx_last    = v.last0;
    pending_w1 = v.send_w1;
    hs         = tx_valid && tx_ready;
    for (int i = 0; i < len; i++) begin
      @(posedge gclk);
      #1;
      if (hs) begin
        if (pending_w1) begin
          tx_data    = v.w1;
          tx_last    = 1'b1;
          pending_w1 = 1'b0;
        end else begin
          tx_valid = 1'b0;
        end
      end
      checkOutput($sformatf("vec%0d_sym%0d", idx, i), v.exp_line[8*(len-1-i) +: 8]);
      hs = tx_valid && tx_ready;
    end
    tx_valid = 1'b0;
  endtask

  initial begin
    reset_l  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;

`ifdef USB_TX_SYNC_GEN_EN
    vecs.push_back('{8'hFF, 1'b1, 8'h00, 1'b0, mk("KJKJKJKKKKKKKJJJJSSJI")});
    vecs.push_back('{8'h00, 1'b1, 8'h00, 1'b0, mk("KJKJKJKKJKJKJKJKSSJI")});
    vecs.push_back('{8'hA5, 1'b0, 8'h00, 1'b0, mk("KJKJKJKKKJJKJJKkUSJI")});
`else
    vecs.push_back('{8'h00, 1'b1, 8'h00, 1'b0, mk("KJKJKJKJSSJI")});
    vecs.push_back('{8'hFF, 1'b1, 8'h00, 1'b0, mk("JJJJJJKKKSSJI")});
    vecs.push_back('{8'h3F, 1'b0, 8'h01, 1'b1, mk("JJJJJJKJkKJKJKJKJSSJI")});
    vecs.push_back('{8'hFC, 1'b0, 8'h00, 1'b1, mk("KJJJJJJJkJKJKJKJKSSJI")});
    vecs.push_back('{8'hA5, 1'b0, 8'h00, 1'b0, mk("JKKJKKJjUSJI")});
    vecs.push_back('{8'h7F, 1'b1, 8'h00, 1'b0, mk("JJJJJJKKJSSJI")});
`endif

    #12;
    checkOutput("in_reset", "I");
    @(negedge gclk);
    reset_l = 1'b1;
    @(posedge gclk);
    #1;
    checkOutput("after_reset", "I");

    for (int v = 0; v < vecs.size(); v++) applyStimulus(vecs[v], v);

    // Reset in the middle of a word: the line falls back to idle J at once, no EOP.
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    tx_last  = 1'b1;
    @(posedge gclk);
    #1;
    tx_valid = 1'b0;
    checkOutput("midrst_bit0", "K");
    @(posedge gclk);
    #1;
    checkOutput("midrst_bit1", "J");
    #2;
    reset_l = 1'b0;
    #1;
    checkOutput("midrst_async", "I");
    @(posedge gclk);
    #1;
    checkOutput("midrst_held", "I");
    @(negedge gclk);
    reset_l = 1'b1;
    @(posedge gclk);
    #1;
    checkOutput("midrst_release", "I");
    applyStimulus(vecs[0], 99);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
